// File: rtl/step_pkg.sv
// Shared types and defaults for the step controller: FSM encoding and parameter defaults.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } step_state_t;

    localparam int DEBOUNCE_N_DEF = 500000;
    localparam int CNT_W_DEF      = 16;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/step_ctrl_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter that accepts
// a new level only after it has differed from the accepted level for DEBOUNCE_N samples.
module debounce
    import step_pkg::*;
#(
    parameter int DEBOUNCE_N = DEBOUNCE_N_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int              CW   = cnt_width(DEBOUNCE_N);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_N - 1);

    logic          sync1_q;
    logic          btn_s_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (btn_s_q != state_q) begin
            if (cnt_q == LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = state_q;

endmodule

// File: rtl/step_ctrl.sv
// Step-enable generator: one-cycle step_en per clk_div rising edge in run mode, or per
// debounced button press in manual mode, plus a free-running count of issued steps.
module step_ctrl
    import step_pkg::*;
#(
    parameter int DEBOUNCE_N = DEBOUNCE_N_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             btn_raw,
    input  logic             run_mode,
    output logic             step_en,
    output logic [CNT_W-1:0] step_cnt,
    output logic             btn_state
);

    logic             btn_db;
    logic             clk_div_q;
    logic             div_rise;
    logic             btn_step;
    step_state_t      state_q, state_d;
    logic             step_en_q, step_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    debounce #(
        .DEBOUNCE_N(DEBOUNCE_N)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .dout (btn_db)
    );

    assign div_rise = clk_div & ~clk_div_q;

    // The FSM follows the button in both modes so a mode switch mid-press cannot re-trigger.
    always_comb begin
        state_d  = state_q;
        btn_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_db) begin
                    state_d  = PRESSED;
                    btn_step = 1'b1;
                end
            end
            PRESSED: state_d = HELD;
            HELD: begin
                if (!btn_db) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step_en_d = (run_mode ? div_rise : btn_step) & ~step_en_q;
        cnt_d     = cnt_q + CNT_W'(step_en_q);
    end

    // Reset loads the current clk_div so a level already high is not taken as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div_q <= clk_div;
            state_q   <= IDLE;
            step_en_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            clk_div_q <= clk_div;
            state_q   <= state_d;
            step_en_q <= step_en_d;
            cnt_q     <= cnt_d;
        end
    end

    assign step_en   = step_en_q;
    assign step_cnt  = cnt_q;
    assign btn_state = btn_db;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: a cycle-level behavioural model predicts every step pulse,
// a negedge monitor pops and compares; directed scenarios are followed by random traffic.
module tb_step_ctrl;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_div = 1'b0;
    logic          btn_raw = 1'b0;
    logic          run_mode = 1'b0;
    logic          step_en;
    logic          btn_state;
    logic [CW-1:0] step_cnt;

    step_ctrl #(
        .DEBOUNCE_N(N),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_div  (clk_div),
        .btn_raw  (btn_raw),
        .run_mode (run_mode),
        .step_en  (step_en),
        .step_cnt (step_cnt),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: button seen two samples late, accepted after N differing samples,
    // a manual step one cycle after each accepted rising level, a run step one cycle after
    // each clk_div rise, never two steps back to back.
    int cyc = 0;
    int m_p1, m_p2, m_run, m_cnt;
    bit m_acc, m_rose, m_prevdiv, m_last;

    always @(posedge clk) begin
        bit seen, manual, runp, pulse;
        cyc++;
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_run = 0; m_cnt = 0;
            m_acc = 0; m_rose = 0; m_last = 0;
            m_prevdiv = clk_div;
        end else begin
            seen = (m_p2 != 0);
            m_p2 = m_p1;
            m_p1 = int'(btn_raw);
            manual = m_rose && !run_mode;
            m_rose = 0;
            if (seen != m_acc) begin
                m_run++;
                if (m_run == N) begin
                    m_acc  = seen;
                    m_rose = seen;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            runp = run_mode && !m_prevdiv && clk_div;
            m_prevdiv = clk_div;
            pulse = (manual || runp) && !m_last;
            if (pulse) begin
                q.push_back('{cyc: cyc, cnt: m_cnt});
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            m_last = pulse;
        end
    end

    int   npulse = 0;
    int   last_pcyc = -1;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            check("missed_pulse", 0, 1);
            void'(q.pop_front());
        end
        if (step_en) begin
            npulse++;
            last_pcyc = cyc;
            if (q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("cnt_at_pulse", int'(step_cnt), e.cnt);
            end
        end
        check("btn_state", int'(btn_state), int'(m_acc));
        check("back_to_back", int'(step_en && prev_en), 0);
        prev_en = step_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0, t0, base, burst;
        burst = 0;

        // reset with button and clk_div high
        rst = 1'b1; btn_raw = 1'b1; clk_div = 1'b1; run_mode = 1'b1;
        tick(3);
        check("reset_step_en", int'(step_en), 0);
        check("reset_step_cnt", int'(step_cnt), 0);
        check("reset_btn_state", int'(btn_state), 0);
        rst = 1'b0;
        p0 = npulse;
        tick(2);
        check("post_reset_quiet", npulse - p0, 0);
        btn_raw = 1'b0;
        tick(12);

        // run mode: five clk_div rising edges, period 20
        base = int'(step_cnt);
        p0 = npulse;
        t0 = 0;
        clk_div = 1'b0;
        tick(10);
        repeat (5) begin
            t0 = cyc;
            clk_div = 1'b1;
            tick(10);
            clk_div = 1'b0;
            tick(10);
        end
        check("run_pulses", npulse - p0, 5);
        check("run_cnt_delta", (int'(step_cnt) - base) & 15, 5);
        check("run_latency", last_pcyc - t0, 1);

        // manual mode: bouncy press then steady
        run_mode = 1'b0;
        tick(2);
        p0 = npulse;
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1;
        t0 = cyc;
        tick(20);
        check("bounce_pulses", npulse - p0, 1);
        check("bounce_latency", last_pcyc - t0, 2 + N + 1);
        btn_raw = 1'b0;
        tick(12);

        // long hold then a second press
        p0 = npulse;
        btn_raw = 1'b1;
        tick(100);
        check("hold_pulses", npulse - p0, 1);
        btn_raw = 1'b0; tick(20);
        btn_raw = 1'b1; tick(20);
        btn_raw = 1'b0; tick(20);
        check("hold_total", npulse - p0, 2);

        // counter wrap: 17 edges on a 4-bit counter
        rst = 1'b1; tick(2); rst = 1'b0;
        run_mode = 1'b1; clk_div = 1'b0;
        tick(4);
        repeat (17) begin
            clk_div = 1'b1; tick(3);
            clk_div = 1'b0; tick(3);
        end
        tick(3);
        check("wrap_cnt", int'(step_cnt), 1);

        // switch run -> step while the button is held
        p0 = npulse;
        btn_raw = 1'b1;
        tick(12);
        run_mode = 1'b0;
        tick(10);
        check("switch_held_no_pulse", npulse - p0, 0);
        btn_raw = 1'b0;
        tick(12);

        // clk_div edge coinciding with step -> run
        clk_div = 1'b0;
        tick(3);
        p0 = npulse;
        t0 = cyc;
        run_mode = 1'b1;
        clk_div = 1'b1;
        tick(3);
        check("mode_edge_pulse", npulse - p0, 1);
        check("mode_edge_latency", last_pcyc - t0, 1);

        // reset arriving with a clk_div edge drops the pulse
        clk_div = 1'b0;
        tick(3);
        p0 = npulse;
        clk_div = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("rst_suppress", npulse - p0, 0);
        check("rst_cnt", int'(step_cnt), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) run_mode = ~run_mode;
            if ($urandom_range(0, 3) == 0) clk_div = ~clk_div;
            if (burst == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                burst = int'($urandom_range(1, 12));
            end else begin
                burst--;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(5);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
